// File: rtl/bias_update_sched.sv
// bias_update_sched: shares the single bias-table port between fetch lookups
// and buffered EX-stage bias updates, and runs a full-table clear sweep.
module bias_update_sched #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    output logic        o_upd_ready,
    input  logic        i_lkp_req,
    output logic        o_lkp_stall,
    input  logic        i_clear,
    output logic        o_clear_busy,
    output logic        o_bt_valid_update,
    output logic [31:0] o_bt_pc,
    output logic        o_bt_actual_taken
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        r_state;
    logic [32:0]   r_fifoMem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_starveCnt;
    logic [7:0]    r_clrIdx;

    logic          w_push;
    logic          w_pop;
    logic [32:0]   w_head;

    assign o_upd_ready  = (r_state == IDLE) && (r_count < FULL_COUNT);
    assign o_clear_busy = (r_state == CLEAR);
    assign w_push       = i_upd_valid && o_upd_ready;
    assign w_head       = r_fifoMem[r_rdPtr];

    // Drain an entry when fetch leaves the port free, or force one once the head has starved long enough
    always_comb begin
        w_pop = 1'b0;
        if (r_state == IDLE) begin
            w_pop = (r_count != '0) && (!i_lkp_req || (r_starveCnt == STARVE_LIM));
        end
    end

    // Steer the table port: clear-sweep writes, a drained FIFO head, or nothing (all zeros)
    always_comb begin
        o_bt_valid_update = 1'b0;
        o_bt_pc           = 32'd0;
        o_bt_actual_taken = 1'b0;
        o_lkp_stall       = 1'b0;
        if (r_state == CLEAR) begin
            o_bt_valid_update = 1'b1;
            o_bt_pc           = {22'd0, r_clrIdx, 2'b00};
            o_bt_actual_taken = 1'b0;
            o_lkp_stall       = i_lkp_req;
        end else if (w_pop) begin
            o_bt_valid_update = 1'b1;
            o_bt_pc           = w_head[32:1];
            o_bt_actual_taken = w_head[0];
            o_lkp_stall       = i_lkp_req;
        end
    end

    // FIFO storage needs no reset; occupancy and pointers decide what is valid
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= {i_upd_pc, i_upd_taken};
        end
    end

    // Control FSM: FIFO bookkeeping and starvation tracking in IDLE, index walk in CLEAR
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_starveCnt <= '0;
            r_clrIdx    <= '0;
        end else if (r_state == IDLE) begin
            if (i_clear) begin
                r_state     <= CLEAR;
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_count     <= '0;
                r_starveCnt <= '0;
                r_clrIdx    <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
                if (w_pop || (r_count == '0)) begin
                    r_starveCnt <= '0;
                end else if (i_lkp_req && (r_starveCnt != STARVE_LIM)) begin
                    r_starveCnt <= r_starveCnt + 4'd1;
                end
            end
        end else begin
            r_clrIdx <= r_clrIdx + 8'd1;
            if (r_clrIdx == 8'hFF) begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_bias_update_sched.sv
// tb_bias_update_sched: directed checks of drain, starvation forcing, clear sweep and reset.
module tb_bias_update_sched;

    logic        clk = 1'b0;
    logic        rstN;
    logic        updValid;
    logic [31:0] updPc;
    logic        updTaken;
    logic        updReady;
    logic        lkpReq;
    logic        lkpStall;
    logic        clearReq;
    logic        clearBusy;
    logic        btValid;
    logic [31:0] btPc;
    logic        btTaken;

    int errCount   = 0;
    int checkCount = 0;

    logic [31:0] pcList [4];
    logic        tkList [4];

    bias_update_sched #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .i_clk             (clk),
        .i_rst_n           (rstN),
        .i_upd_valid       (updValid),
        .i_upd_pc          (updPc),
        .i_upd_taken       (updTaken),
        .o_upd_ready       (updReady),
        .i_lkp_req         (lkpReq),
        .o_lkp_stall       (lkpStall),
        .i_clear           (clearReq),
        .o_clear_busy      (clearBusy),
        .o_bt_valid_update (btValid),
        .o_bt_pc           (btPc),
        .o_bt_actual_taken (btTaken)
    );

    // Free-running 10ns clock
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle and drive inputs shortly after the rising edge
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic t,
                                 input logic lkp, input logic clr);
        @(posedge clk);
        #1;
        updValid = v;
        updPc    = pc;
        updTaken = t;
        lkpReq   = lkp;
        clearReq = clr;
        #1;
    endtask

    // Compare every output at once, packed as {valid, pc, taken, stall, ready, busy}
    task automatic checkBus(input string tag, input logic eValid, input logic [31:0] ePc,
                            input logic eTaken, input logic eStall, input logic eReady,
                            input logic eBusy);
        checkOutput(tag, {27'd0, btValid, btPc, btTaken, lkpStall, updReady, clearBusy},
                         {27'd0, eValid, ePc, eTaken, eStall, eReady, eBusy});
    endtask

    // Full 256-cycle sweep with lookups toggling; optionally re-pulse clear at one index
    task automatic runSweep(input string tag, input int pulseAt);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            logic       lkp;
            idx = 8'(i);
            lkp = idx[0];
            applyStimulus(1'b1, 32'hDEAD_0000, 1'b1, lkp, (i == pulseAt));
            checkBus(tag, 1'b1, {22'd0, idx, 2'b00}, 1'b0, lkp, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus({tag, "_done"}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus({tag, "_quiet"}, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Push four entries while fetch holds the port; the FIFO ends full with the head starved
    task automatic fillWithLookups(input string tag, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            pcList[k] = base + 32'(k * 16);
            tkList[k] = (k % 2 == 0);
            applyStimulus(1'b1, pcList[k], tkList[k], 1'b1, 1'b0);
            checkBus(tag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        updValid = 1'b0;
        updPc    = 32'd0;
        updTaken = 1'b0;
        lkpReq   = 1'b1;
        clearReq = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkBus("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rstN   = 1'b1;
        lkpReq = 1'b0;

        // Single update through an idle port: accepted, then written next cycle
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
        checkBus("t1_accept", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t1_write", 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t1_empty", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Continuous lookups: each head waits three blocked cycles, then is forced
        fillWithLookups("t2_push", 32'h1000_0004);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkBus("t2_force0", 1'b1, pcList[0], tkList[0], 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            for (int b = 0; b < 3; b++) begin
                applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
                checkBus("t2_block", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            checkBus("t2_force", 1'b1, pcList[k], tkList[k], 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkBus("t2_empty", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full FIFO drains one per cycle once lookups stop; a push during drain keeps count at 3
        fillWithLookups("t3_push", 32'h2000_0100);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t3_drain0", 1'b1, pcList[0], tkList[0], 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2000_0800, 1'b1, 1'b0, 1'b0);
        checkBus("t3_drain1", 1'b1, pcList[1], tkList[1], 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t3_drain2", 1'b1, pcList[2], tkList[2], 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t3_drain3", 1'b1, pcList[3], tkList[3], 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t3_drain4", 1'b1, 32'h2000_0800, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkBus("t3_empty", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Two queued entries are discarded by a clear; the sweep writes every index with 0
        applyStimulus(1'b1, 32'h3000_0044, 1'b1, 1'b1, 1'b0);
        checkBus("t4_pushX", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h3000_0048, 1'b1, 1'b1, 1'b0);
        checkBus("t4_pushY", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkBus("t4_clrcyc", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        runSweep("t4_sweep", -1);

        // Asynchronous reset at index 100 of a sweep, then a fresh sweep from index 0
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkBus("t5_clrcyc", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i <= 100; i++) begin
            logic [7:0] idx;
            idx = 8'(i);
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            checkBus("t5_pre", 1'b1, {22'd0, idx, 2'b00}, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        lkpReq = 1'b1;
        rstN   = 1'b0;
        #1;
        checkBus("t5_async", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        checkBus("t5_held", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rstN   = 1'b1;
        lkpReq = 1'b0;

        // Restarted sweep begins at index 0; a clear pulse at index 10 is ignored
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkBus("t6_clrcyc", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        runSweep("t6_sweep", 10);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
